// File: rtl/register_stack.sv
// LIFO register stack with registered top-of-stack, full/empty and sticky errors.
// Define REGISTER_STACK_COUNT_EN to expose the entry count as count_out.
module register_stack #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  clr_err,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  empty,
   output logic                  full,
   output logic                  overflow,
   output logic                  underflow
`ifdef REGISTER_STACK_COUNT_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] count_out
`endif
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [CW-1:0]         count;
   logic [CW-1:0]         cnt_nxt;
   logic [DATA_WIDTH-1:0] dout_nxt;
   logic [IW-1:0]         wr_idx;
   logic [IW-1:0]         rd_idx;
   logic                  wr_en;
   logic                  ovf_set;
   logic                  unf_set;

   assign rd_idx = IW'(count - CW'(2));

   // Exactly one arm matches for every push/pop/count combination.
   always_comb begin
      cnt_nxt  = count;
      dout_nxt = data_out;
      wr_idx   = '0;
      wr_en    = 1'b0;
      ovf_set  = 1'b0;
      unf_set  = 1'b0;
      unique case (1'b1)
         (!push && !pop): begin
         end
         (push && !pop && !full): begin
            wr_en    = 1'b1;
            wr_idx   = IW'(count);
            cnt_nxt  = count + CW'(1);
            dout_nxt = data_in;
         end
         (push && !pop && full): begin
            ovf_set = 1'b1;
         end
         (pop && !push && count >= CW'(2)): begin
            cnt_nxt  = count - CW'(1);
            dout_nxt = mem[rd_idx];
         end
         (pop && !push && count == CW'(1)): begin
            cnt_nxt  = '0;
            dout_nxt = '0;
         end
         (pop && !push && count == '0): begin
            unf_set = 1'b1;
         end
         (push && pop && count != '0): begin
            wr_en    = 1'b1;
            wr_idx   = IW'(count - CW'(1));
            dout_nxt = data_in;
         end
         (push && pop && count == '0): begin
            wr_en    = 1'b1;
            wr_idx   = '0;
            cnt_nxt  = CW'(1);
            dout_nxt = data_in;
            unf_set  = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= data_in;
      end
   end

   // A new error event takes priority over clr_err on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count     <= '0;
         data_out  <= '0;
         empty     <= 1'b1;
         full      <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         count     <= cnt_nxt;
         data_out  <= dout_nxt;
         empty     <= (cnt_nxt == '0);
         full      <= (cnt_nxt == CW'(DEPTH));
         overflow  <= ovf_set | (overflow & ~clr_err);
         underflow <= unf_set | (underflow & ~clr_err);
      end
   end

`ifdef REGISTER_STACK_COUNT_EN
   assign count_out = count;
`endif

endmodule
